// File: rtl/graph_mem_pkg.sv
// Shared defaults and types for the two-port graph memory read arbiter.
// The port helper is used by the round-robin grant logic.
package graph_mem_pkg;

  localparam int ADDR_W_DEF      = 32;
  localparam int DATA_W_DEF      = 32;
  localparam int MEM_LATENCY_DEF = 2;

  typedef enum logic {
    PORT0 = 1'b0,
    PORT1 = 1'b1
  } port_id_t;

  function automatic port_id_t other_port(input port_id_t p);
    case (p)
      PORT0:   return PORT1;
      PORT1:   return PORT0;
      default: return PORT0;
    endcase
  endfunction

endpackage

// File: rtl/graph_mem_arbiter_fifo.sv
// Small pending-request FIFO with a registered occupancy counter.
// Pushes are refused when full, and pops are refused when empty.
module graph_mem_arbiter_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 32
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic             push_s;
  logic             pop_s;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(DEPTH - 1)) begin
      return '0;
    end else begin
      return p + 1'b1;
    end
  endfunction

  assign full    = (count_r == CNT_W'(DEPTH));
  assign empty   = (count_r == '0);
  assign push_s  = push && !full;
  assign pop_s   = pop && !empty;
  assign rd_data = mem_r[rd_ptr_r];

  // Storage array; contents need no reset because occupancy guards reads.
  always_ff @(posedge clk_in) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= wr_data;
    end
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= next_ptr(wr_ptr_r);
      end
      if (pop_s) begin
        rd_ptr_r <= next_ptr(rd_ptr_r);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + 1'b1;
        2'b01:   count_r <= count_r - 1'b1;
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/graph_mem_arbiter.sv
// Two-port round-robin read arbiter in front of a fixed-latency BRAM.
// A tag pipeline routes each returning word to the port that issued it.
module graph_mem_arbiter
  import graph_mem_pkg::*;
#(
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int DATA_W      = DATA_W_DEF,
  parameter int MEM_LATENCY = MEM_LATENCY_DEF,
  parameter int QDEPTH      = 2
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              req0_valid_in,
  input  logic [ADDR_W-1:0] req0_addr_in,
  output logic              req0_ready_out,
  output logic              resp0_valid_out,
  output logic [DATA_W-1:0] resp0_data_out,
  input  logic              req1_valid_in,
  input  logic [ADDR_W-1:0] req1_addr_in,
  output logic              req1_ready_out,
  output logic              resp1_valid_out,
  output logic [DATA_W-1:0] resp1_data_out,
  output logic              mem_en_out,
  output logic [ADDR_W-1:0] mem_addr_out,
  input  logic [DATA_W-1:0] mem_data_in,
  output logic              overflow_out
);

  logic [ADDR_W-1:0] head0_s;
  logic [ADDR_W-1:0] head1_s;
  logic              full0_s;
  logic              full1_s;
  logic              empty0_s;
  logic              empty1_s;
  logic              push0_s;
  logic              push1_s;
  logic              pop0_s;
  logic              pop1_s;
  logic              grant_valid_s;
  port_id_t          grant_port_s;
  logic [ADDR_W-1:0] grant_addr_s;

  port_id_t          last_grant_r;
  port_id_t          mem_port_r;
  logic              mem_en_r;
  logic [ADDR_W-1:0] mem_addr_r;
  logic              overflow_r;
  logic              tag_valid_r [MEM_LATENCY];
  port_id_t          tag_port_r  [MEM_LATENCY];

  // Readiness comes from registered occupancy, so a full queue drops even if it pops this cycle.
  assign push0_s = req0_valid_in && !full0_s;
  assign push1_s = req1_valid_in && !full1_s;
  assign pop0_s  = grant_valid_s && (grant_port_s == PORT0);
  assign pop1_s  = grant_valid_s && (grant_port_s == PORT1);

  graph_mem_arbiter_fifo #(
    .DEPTH (QDEPTH),
    .WIDTH (ADDR_W)
  ) u_queue0 (
    .clk_in  (clk_in),
    .rst_in  (rst_in),
    .push    (push0_s),
    .wr_data (req0_addr_in),
    .pop     (pop0_s),
    .rd_data (head0_s),
    .full    (full0_s),
    .empty   (empty0_s)
  );

  graph_mem_arbiter_fifo #(
    .DEPTH (QDEPTH),
    .WIDTH (ADDR_W)
  ) u_queue1 (
    .clk_in  (clk_in),
    .rst_in  (rst_in),
    .push    (push1_s),
    .wr_data (req1_addr_in),
    .pop     (pop1_s),
    .rd_data (head1_s),
    .full    (full1_s),
    .empty   (empty1_s)
  );

  // Round-robin grant: on contention the port that did not win last time goes first.
  always_comb begin
    grant_valid_s = 1'b0;
    grant_port_s  = last_grant_r;
    grant_addr_s  = head0_s;
    if (!empty0_s && !empty1_s) begin
      grant_valid_s = 1'b1;
      grant_port_s  = other_port(last_grant_r);
    end else if (!empty0_s) begin
      grant_valid_s = 1'b1;
      grant_port_s  = PORT0;
    end else if (!empty1_s) begin
      grant_valid_s = 1'b1;
      grant_port_s  = PORT1;
    end else begin
      grant_valid_s = 1'b0;
      grant_port_s  = last_grant_r;
    end
    if (grant_port_s == PORT1) begin
      grant_addr_s = head1_s;
    end else begin
      grant_addr_s = head0_s;
    end
  end

  // Memory issue registers; the address holds while idle.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      mem_en_r     <= 1'b0;
      mem_addr_r   <= '0;
      mem_port_r   <= PORT0;
      last_grant_r <= PORT1;
    end else begin
      mem_en_r <= grant_valid_s;
      if (grant_valid_s) begin
        mem_addr_r   <= grant_addr_s;
        mem_port_r   <= grant_port_s;
        last_grant_r <= grant_port_s;
      end
    end
  end

  // Sticky drop flag.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      overflow_r <= 1'b0;
    end else if ((req0_valid_in && full0_s) || (req1_valid_in && full1_s)) begin
      overflow_r <= 1'b1;
    end
  end

  // Tag pipeline tracks reads in flight; clearing it on reset squashes stale returns.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      for (int i = 0; i < MEM_LATENCY; i++) begin
        tag_valid_r[i] <= 1'b0;
        tag_port_r[i]  <= PORT0;
      end
    end else begin
      tag_valid_r[0] <= mem_en_r;
      tag_port_r[0]  <= mem_port_r;
      for (int i = 1; i < MEM_LATENCY; i++) begin
        tag_valid_r[i] <= tag_valid_r[i-1];
        tag_port_r[i]  <= tag_port_r[i-1];
      end
    end
  end

  assign req0_ready_out  = !full0_s;
  assign req1_ready_out  = !full1_s;
  assign mem_en_out      = mem_en_r;
  assign mem_addr_out    = mem_addr_r;
  assign overflow_out    = overflow_r;
  assign resp0_valid_out = tag_valid_r[MEM_LATENCY-1] && (tag_port_r[MEM_LATENCY-1] == PORT0);
  assign resp1_valid_out = tag_valid_r[MEM_LATENCY-1] && (tag_port_r[MEM_LATENCY-1] == PORT1);
  assign resp0_data_out  = mem_data_in;
  assign resp1_data_out  = mem_data_in;

endmodule

// File: tb/tb_graph_mem_arbiter.sv
// Directed bench for graph_mem_arbiter with a two-cycle BRAM model.
// Expected addresses, routing and data are hand-derived per scenario.
module tb_graph_mem_arbiter;
  import graph_mem_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk_in = 1'b0;
  logic          rst_in = 1'b1;
  logic          req0_valid_in = 1'b0;
  logic [AW-1:0] req0_addr_in = '0;
  logic          req0_ready_out;
  logic          resp0_valid_out;
  logic [DW-1:0] resp0_data_out;
  logic          req1_valid_in = 1'b0;
  logic [AW-1:0] req1_addr_in = '0;
  logic          req1_ready_out;
  logic          resp1_valid_out;
  logic [DW-1:0] resp1_data_out;
  logic          mem_en_out;
  logic [AW-1:0] mem_addr_out;
  logic [DW-1:0] mem_data_in;
  logic          overflow_out;

  int n_cmp = 0;
  int n_err = 0;
  logic [AW-1:0] rr_exp [8];

  graph_mem_arbiter #(
    .ADDR_W      (AW),
    .DATA_W      (DW),
    .MEM_LATENCY (2),
    .QDEPTH      (2)
  ) dut (
    .clk_in          (clk_in),
    .rst_in          (rst_in),
    .req0_valid_in   (req0_valid_in),
    .req0_addr_in    (req0_addr_in),
    .req0_ready_out  (req0_ready_out),
    .resp0_valid_out (resp0_valid_out),
    .resp0_data_out  (resp0_data_out),
    .req1_valid_in   (req1_valid_in),
    .req1_addr_in    (req1_addr_in),
    .req1_ready_out  (req1_ready_out),
    .resp1_valid_out (resp1_valid_out),
    .resp1_data_out  (resp1_data_out),
    .mem_en_out      (mem_en_out),
    .mem_addr_out    (mem_addr_out),
    .mem_data_in     (mem_data_in),
    .overflow_out    (overflow_out)
  );

  always #5 clk_in = ~clk_in;

  function automatic logic [DW-1:0] bram_word(input logic [AW-1:0] a);
    return {a[15:0] ^ 16'hBEEF, a[15:0]};
  endfunction

  // Two-cycle BRAM: data for a read enabled in cycle n appears in cycle n+2.
  logic [DW-1:0] bram_d1_r = '0;
  logic [DW-1:0] bram_d2_r = '0;
  always @(posedge clk_in) begin
    if (mem_en_out) bram_d1_r <= bram_word(mem_addr_out);
    bram_d2_r <= bram_d1_r;
  end
  assign mem_data_in = bram_d2_r;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic idle_inputs();
    req0_valid_in = 1'b0;
    req1_valid_in = 1'b0;
    req0_addr_in  = '0;
    req1_addr_in  = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_in = 1'b1;
    tick();
    tick();
    rst_in = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_mem_en"},   mem_en_out,      0);
    check_eq({tag, "_mem_addr"}, mem_addr_out,    0);
    check_eq({tag, "_resp0_v"},  resp0_valid_out, 0);
    check_eq({tag, "_resp1_v"},  resp1_valid_out, 0);
    check_eq({tag, "_overflow"}, overflow_out,    0);
    check_eq({tag, "_ready0"},   req0_ready_out,  1);
    check_eq({tag, "_ready1"},   req1_ready_out,  1);
  endtask

  initial begin
    rr_exp[0] = 32'h100; rr_exp[1] = 32'h200; rr_exp[2] = 32'h101; rr_exp[3] = 32'h201;
    rr_exp[4] = 32'h102; rr_exp[5] = 32'h203; rr_exp[6] = 32'h104; rr_exp[7] = 32'h205;

    // Reset values
    #1;
    tick();
    check_reset_outputs("rst");
    rst_in = 1'b0;
    tick();

    // Single uncontended port-0 read
    do_reset();
    req0_valid_in = 1'b1; req0_addr_in = 32'h10;
    tick();
    idle_inputs();
    check_eq("single_no_early_en", mem_en_out, 0);
    tick();
    check_eq("single_en", mem_en_out, 1);
    check_eq("single_addr", mem_addr_out, 32'h10);
    tick();
    check_eq("single_no_early_resp", resp0_valid_out, 0);
    tick();
    check_eq("single_resp0_v", resp0_valid_out, 1);
    check_eq("single_resp0_d", resp0_data_out, bram_word(32'h10));
    check_eq("single_resp1_v", resp1_valid_out, 0);
    tick();
    check_eq("single_resp_done", resp0_valid_out, 0);

    // Simultaneous first requests after reset: port 0 wins
    do_reset();
    req0_valid_in = 1'b1; req0_addr_in = 32'h20;
    req1_valid_in = 1'b1; req1_addr_in = 32'h30;
    tick();
    idle_inputs();
    tick();
    check_eq("sim_first_addr", mem_addr_out, 32'h20);
    tick();
    check_eq("sim_second_en", mem_en_out, 1);
    check_eq("sim_second_addr", mem_addr_out, 32'h30);
    tick();
    check_eq("sim_idle_en", mem_en_out, 0);
    check_eq("sim_resp0_v", resp0_valid_out, 1);
    check_eq("sim_resp0_d", resp0_data_out, bram_word(32'h20));
    check_eq("sim_resp1_quiet", resp1_valid_out, 0);
    tick();
    check_eq("sim_resp1_v", resp1_valid_out, 1);
    check_eq("sim_resp1_d", resp1_data_out, bram_word(32'h30));
    check_eq("sim_resp0_quiet", resp0_valid_out, 0);

    // Both ports requesting every cycle: strict alternation
    do_reset();
    for (int i = 0; i < 8; i++) begin
      req0_valid_in = 1'b1; req0_addr_in = 32'h100 + i;
      req1_valid_in = 1'b1; req1_addr_in = 32'h200 + i;
      tick();
      if (i >= 1) begin
        check_eq($sformatf("rr_en_%0d", i - 1), mem_en_out, 1);
        check_eq($sformatf("rr_addr_%0d", i - 1), mem_addr_out, rr_exp[i-1]);
      end
    end
    idle_inputs();
    tick();
    check_eq("rr_en_7", mem_en_out, 1);
    check_eq("rr_addr_7", mem_addr_out, rr_exp[7]);
    check_eq("rr_overflow", overflow_out, 1);
    for (int i = 0; i < 6; i++) tick();

    // Third back-to-back port-0 request dropped while port 1 saturates memory
    do_reset();
    req0_valid_in = 1'b1; req0_addr_in = 32'h40;
    tick();
    idle_inputs();
    for (int i = 0; i < 5; i++) tick();
    check_eq("ovf_pre_clear", overflow_out, 0);
    for (int i = 0; i < 6; i++) begin
      req1_valid_in = 1'b1; req1_addr_in = 32'h300 + i;
      req0_valid_in = (i < 3);
      req0_addr_in  = 32'h50 + i;
      tick();
      case (i)
        0: check_eq("ovf_e1_en", mem_en_out, 0);
        1: begin
          check_eq("ovf_e2_addr", mem_addr_out, 32'h300);
          check_eq("ovf_e2_ready0", req0_ready_out, 0);
          check_eq("ovf_e2_flag", overflow_out, 0);
        end
        2: begin
          check_eq("ovf_e3_addr", mem_addr_out, 32'h50);
          check_eq("ovf_e3_flag", overflow_out, 1);
        end
        3: begin
          check_eq("ovf_e4_addr", mem_addr_out, 32'h301);
          check_eq("ovf_e4_resp1_v", resp1_valid_out, 1);
          check_eq("ovf_e4_resp1_d", resp1_data_out, bram_word(32'h300));
        end
        4: begin
          check_eq("ovf_e5_addr", mem_addr_out, 32'h51);
          check_eq("ovf_e5_resp0_v", resp0_valid_out, 1);
          check_eq("ovf_e5_resp0_d", resp0_data_out, bram_word(32'h50));
        end
        default: begin
          check_eq("ovf_e6_addr", mem_addr_out, 32'h302);
          check_eq("ovf_e6_resp0_v", resp0_valid_out, 0);
          check_eq("ovf_e6_resp1_d", resp1_data_out, bram_word(32'h301));
        end
      endcase
    end
    idle_inputs();
    tick();
    check_eq("ovf_e7_resp0_v", resp0_valid_out, 1);
    check_eq("ovf_e7_resp0_d", resp0_data_out, bram_word(32'h51));
    check_eq("ovf_e7_resp1_v", resp1_valid_out, 0);
    check_eq("ovf_sticky", overflow_out, 1);
    for (int i = 0; i < 6; i++) tick();

    // Reset while a read is in flight
    do_reset();
    req0_valid_in = 1'b1; req0_addr_in = 32'h60;
    tick();
    idle_inputs();
    tick();
    check_eq("mid_en", mem_en_out, 1);
    check_eq("mid_addr", mem_addr_out, 32'h60);
    tick();
    rst_in = 1'b1;
    #1;
    check_reset_outputs("mid_rst");
    tick();
    check_eq("mid_rst_resp0", resp0_valid_out, 0);
    rst_in = 1'b0;
    tick();
    check_eq("mid_post1_resp0", resp0_valid_out, 0);
    check_eq("mid_post1_resp1", resp1_valid_out, 0);
    tick();
    check_eq("mid_post2_resp0", resp0_valid_out, 0);
    req0_valid_in = 1'b1; req0_addr_in = 32'h70;
    tick();
    idle_inputs();
    tick();
    check_eq("mid_new_en", mem_en_out, 1);
    check_eq("mid_new_addr", mem_addr_out, 32'h70);
    tick();
    tick();
    check_eq("mid_new_resp0_v", resp0_valid_out, 1);
    check_eq("mid_new_resp0_d", resp0_data_out, bram_word(32'h70));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
